// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-master memory port arbiter: FSM encoding,
// arbitration mode constants and the out-of-range address test.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // True when the byte address points past the last RAM word.
  function automatic logic is_oor(input logic [31:0] addr, input int unsigned mem_size);
    return ({2'b00, addr[31:2]} >= 32'(mem_size));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// picorv32 native memory interface: one request/response channel per master.
interface mem_port_arbiter_if;

  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way grant selection: a lone requester always wins; on a tie the mode
// picks either the master not granted last time or always master 0.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  input  logic       mode_i,      // 1 = fixed priority, m0 wins ties
  output logic       gnt_o
);

  // Grant index from the current request pair.
  always_comb begin
    // NOTE: every path assigns gnt_o via this default, so no latch is inferred.
    gnt_o = 1'b0;
    case (req_i)
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = mode_i ? 1'b0 : ~last_gnt_i;
      default: gnt_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between two native-interface masters.
// One access per three cycles: IDLE (arbitrate/latch) -> ISSUE (RAM strobe)
// -> RESP (ready pulse, read data straight from the RAM output).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_SIZE  = 1024,
  parameter int ADDR_BITS = $clog2(MEM_SIZE),
  parameter int ARB_MODE  = ARB_RR
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    m0,
  mem_port_arbiter_if.slave    m1,
  output logic                 ram_en,
  output logic [3:0]           ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata,
  output logic                 busy,
  output logic                 err_pulse
);

  arb_state_e           state_q;
  logic                 gnt_q;
  logic                 last_gnt_q;
  logic                 oor_q;
  logic [3:0]           wstrb_q;
  logic [1:0]           ready_q;
  logic                 err_q;
  logic                 ram_en_q;
  logic [3:0]           ram_we_q;
  logic [ADDR_BITS-1:0] ram_addr_q;
  logic [31:0]          ram_wdata_q;

  logic        gnt_d;
  logic        oor_d;
  logic [31:0] sel_addr_d;
  logic [31:0] sel_wdata_d;
  logic [3:0]  sel_wstrb_d;
  logic [31:0] resp_data;
  logic        unused_addr_lsb;

  rr_arb2 u_arb (
    .req_i      ({m1.valid, m0.valid}),
    .last_gnt_i (last_gnt_q),
    .mode_i     (ARB_MODE == ARB_FIXED),
    .gnt_o      (gnt_d)
  );

  assign sel_addr_d      = gnt_d ? m1.addr  : m0.addr;
  assign sel_wdata_d     = gnt_d ? m1.wdata : m0.wdata;
  assign sel_wstrb_d     = gnt_d ? m1.wstrb : m0.wstrb;
  assign oor_d           = is_oor(sel_addr_d, MEM_SIZE);
  assign unused_addr_lsb = ^sel_addr_d[1:0];

  // Arbitration, request latching and registered RAM/response strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      oor_q       <= 1'b0;
      wstrb_q     <= '0;
      ready_q     <= '0;
      err_q       <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state_q)
        IDLE: begin
          if (m0.valid || m1.valid) begin
            gnt_q       <= gnt_d;
            oor_q       <= oor_d;
            wstrb_q     <= sel_wstrb_d;
            ram_en_q    <= !oor_d;
            // Out-of-range writes are dropped, never reach the RAM.
            ram_we_q    <= oor_d ? 4'h0 : sel_wstrb_d;
            ram_addr_q  <= sel_addr_d[ADDR_BITS+1:2];
            ram_wdata_q <= sel_wdata_d;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          ram_en_q <= 1'b0;
          ram_we_q <= '0;
          ready_q  <= gnt_q ? 2'b10 : 2'b01;
          err_q    <= oor_q;
          state_q  <= RESP;
        end
        RESP: begin
          ready_q    <= '0;
          err_q      <= 1'b0;
          last_gnt_q <= gnt_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM output is valid in RESP; writes and out-of-range accesses return zero.
  assign resp_data = (oor_q || (wstrb_q != 4'h0)) ? 32'h0 : ram_rdata;

  assign m0.ready  = ready_q[0];
  assign m1.ready  = ready_q[1];
  assign m0.rdata  = ready_q[0] ? resp_data : 32'h0;
  assign m1.rdata  = ready_q[1] ? resp_data : 32'h0;

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != IDLE);
  assign err_pulse = err_q;

endmodule
